// File: rtl/awg_chirp_sequencer_pkg.sv
// awg_chirp_sequencer_pkg: shared state encoding, control bits and default settings addresses
package awg_chirp_sequencer_pkg;
  typedef enum logic [1:0] {ST_WARMUP, ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam int CTRL_DOWN = 0;
  localparam int CTRL_CONT = 1;
  localparam logic [7:0] SR_FREQ_OFFSET_DEF = 8'd3;
  localparam logic [7:0] SR_TUNING_COEF_DEF = 8'd4;
  localparam logic [7:0] SR_COUNTER_MAX_DEF = 8'd5;
  localparam logic [7:0] SR_CTRL_WORD_DEF = 8'd6;
endpackage

// File: rtl/chirp_phase_accum.sv
// chirp_phase_accum: linear-FM frequency and phase accumulators with load/step/clear
module chirp_phase_accum (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  logic        keep,
  input  logic        down,
  input  logic [31:0] freq_init,
  input  logic [31:0] coef,
  output logic [31:0] phase
);
  logic [31:0] freq, phase_n, freq_n;
  always_comb begin
    phase_n = load ? (keep ? phase : '0) : clear ? '0 : step ? phase + freq : phase;
    freq_n = load ? freq_init : step ? (down ? freq - coef : freq + coef) : freq;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      freq <= '0;
    end else begin
      phase <= phase_n;
      freq <= freq_n;
    end
  end
endmodule

// File: rtl/awg_chirp_sequencer.sv
// awg_chirp_sequencer: chirp handshake responder, settings decode and linear-FM DDS phase stream
module awg_chirp_sequencer
  import awg_chirp_sequencer_pkg::*;
#(
  parameter logic [7:0]  SR_FREQ_OFFSET_ADDR = SR_FREQ_OFFSET_DEF,
  parameter logic [7:0]  SR_TUNING_COEF_ADDR = SR_TUNING_COEF_DEF,
  parameter logic [7:0]  SR_COUNTER_MAX_ADDR = SR_COUNTER_MAX_DEF,
  parameter logic [7:0]  SR_CTRL_WORD_ADDR = SR_CTRL_WORD_DEF,
  parameter logic [31:0] FREQ_OFFSET_INIT = 32'h0000_0000,
  parameter logic [31:0] TUNING_COEF_INIT = 32'h0000_0001,
  parameter logic [31:0] COUNTER_MAX_INIT = 32'h0000_0fff,
  parameter logic [31:0] CTRL_WORD_INIT = 32'h0000_0000,
  parameter int          WARMUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        dac_ready,
  input  logic        awg_init,
  input  logic        awg_enable,
  output logic        awg_ready,
  output logic        awg_active,
  output logic        awg_done,
  output logic [31:0] phase_out,
  output logic        phase_valid
);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
  state_t state, state_n;
  logic [31:0] freq_offset, tuning_coef, counter_max, coef_sh, cmax_sh, smp_cnt, phase;
  logic [1:0] ctrl, ctrl_sh;
  logic [15:0] warm_cnt;
  logic start, run;
  assign run = state == ST_RUN;
  assign start = (state == ST_IDLE) & awg_init & awg_enable & awg_ready;
  assign awg_active = run;
  assign phase_valid = run;
  assign awg_done = state == ST_DONE;
  assign phase_out = run ? phase : '0;
  // only the two defined control bits carry behaviour; reserved bits are not retained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_offset <= FREQ_OFFSET_INIT;
      tuning_coef <= TUNING_COEF_INIT;
      counter_max <= COUNTER_MAX_INIT;
      ctrl <= CTRL_WORD_INIT[1:0];
    end else if (set_stb) begin
      if (set_addr == SR_FREQ_OFFSET_ADDR) freq_offset <= set_data;
      if (set_addr == SR_TUNING_COEF_ADDR) tuning_coef <= set_data;
      if (set_addr == SR_COUNTER_MAX_ADDR) counter_max <= set_data;
      if (set_addr == SR_CTRL_WORD_ADDR) ctrl <= set_data[1:0];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WARMUP;
      warm_cnt <= '0;
      smp_cnt <= '0;
      coef_sh <= '0;
      cmax_sh <= '0;
      ctrl_sh <= '0;
      awg_ready <= 1'b0;
    end else begin
      state <= state_n;
      warm_cnt <= state == ST_WARMUP ? warm_cnt + 16'd1 : warm_cnt;
      smp_cnt <= start ? '0 : run ? smp_cnt + 32'd1 : smp_cnt;
      coef_sh <= start ? tuning_coef : coef_sh;
      cmax_sh <= start ? counter_max : cmax_sh;
      ctrl_sh <= start ? ctrl : ctrl_sh;
      awg_ready <= dac_ready & (state == ST_IDLE | state == ST_DONE) & ~start;
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      ST_WARMUP: state_n = warm_cnt == WARM_LAST ? ST_IDLE : ST_WARMUP;
      ST_IDLE:   state_n = start ? ST_RUN : ST_IDLE;
      ST_RUN:    state_n = !awg_enable ? ST_IDLE : smp_cnt == cmax_sh ? ST_DONE : ST_RUN;
      default:   state_n = ST_IDLE;
    endcase
  end
  chirp_phase_accum u_accum (
    .clk(clk),
    .reset_n(reset_n),
    .load(start),
    .step(run),
    .clear(run & ~awg_enable & ~ctrl_sh[CTRL_CONT]),
    .keep(ctrl[CTRL_CONT]),
    .down(ctrl_sh[CTRL_DOWN]),
    .freq_init(freq_offset),
    .coef(coef_sh),
    .phase(phase)
  );
endmodule

// File: tb/tb_awg_chirp_sequencer.sv
// tb_awg_chirp_sequencer: directed plus randomized chirps against a closed-form phase model
module tb_awg_chirp_sequencer;
  import awg_chirp_sequencer_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, set_stb = 1'b0, dac_ready = 1'b1, awg_init = 1'b0, awg_enable = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic awg_ready, awg_active, awg_done, phase_valid;
  logic [31:0] phase_out;
  int compared = 0, mismatched = 0;
  logic [31:0] m_fo, m_tc, m_cm, m_phase;
  logic [1:0] m_cw;

  awg_chirp_sequencer dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .dac_ready(dac_ready), .awg_init(awg_init), .awg_enable(awg_enable), .awg_ready(awg_ready),
    .awg_active(awg_active), .awg_done(awg_done), .phase_out(phase_out), .phase_valid(phase_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // phase of sample k of a linear-FM chirp: p0 + k*f0 +/- coef*k*(k-1)/2, modulo 2^32
  function automatic logic [31:0] exp_phase(input logic [31:0] p0, f0, c, input bit down, input int k);
    logic [31:0] tri_n, d;
    tri_n = 32'((longint'(k) * (k - 1)) / 2);
    d = c * tri_n;
    return p0 + f0 * 32'(k) + (down ? -d : d);
  endfunction

  task automatic model_reset();
    m_fo = 32'h0; m_tc = 32'h1; m_cm = 32'hfff; m_cw = 2'b00; m_phase = 32'h0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    if (a == SR_FREQ_OFFSET_DEF) m_fo = d;
    if (a == SR_TUNING_COEF_DEF) m_tc = d;
    if (a == SR_COUNTER_MAX_DEF) m_cm = d;
    if (a == SR_CTRL_WORD_DEF) m_cw = d[1:0];
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
    model_write(a, d);
  endtask

  task automatic warmup();
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      check($sformatf("warmup_ready_c%0d", e), 32'(awg_ready), 32'(e == 17));
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !awg_ready; i++) @(negedge clk);
    check("ready_wait", 32'(awg_ready), 32'd1);
  endtask

  task automatic run_chirp(input int abort_after, input bit mid_cm, input logic [31:0] new_cm,
                           input bit same_wr, input logic [31:0] new_tc, input bit mid_init);
    logic [31:0] p0, f0, c;
    bit down, cont;
    int n, emitted;
    wait_ready();
    p0 = m_cw[1] ? m_phase : 32'h0;
    f0 = m_fo; c = m_tc; down = m_cw[0]; cont = m_cw[1]; n = int'(m_cm) + 1;
    emitted = abort_after > 0 ? abort_after : n;
    awg_init = 1'b1; awg_enable = 1'b1;
    if (same_wr) begin set_stb = 1'b1; set_addr = SR_TUNING_COEF_DEF; set_data = new_tc; end
    @(negedge clk);
    awg_init = 1'b0; set_stb = 1'b0;
    if (same_wr) model_write(SR_TUNING_COEF_DEF, new_tc);
    for (int k = 0; k < emitted; k++) begin
      check($sformatf("valid_s%0d", k), 32'(phase_valid), 32'd1);
      check($sformatf("active_s%0d", k), 32'(awg_active), 32'd1);
      check($sformatf("done_s%0d", k), 32'(awg_done), 32'd0);
      check($sformatf("phase_s%0d", k), phase_out, exp_phase(p0, f0, c, down, k));
      set_stb = 1'b0; awg_init = 1'b0;
      if (mid_cm && k == 1) begin
        set_stb = 1'b1; set_addr = SR_COUNTER_MAX_DEF; set_data = new_cm;
        model_write(SR_COUNTER_MAX_DEF, new_cm);
      end
      if (mid_init && k == 1) awg_init = 1'b1;
      if (abort_after > 0 && k == emitted - 1) awg_enable = 1'b0;
      @(negedge clk);
    end
    set_stb = 1'b0; awg_init = 1'b0;
    check("end_valid", 32'(phase_valid), 32'd0);
    check("end_active", 32'(awg_active), 32'd0);
    check("end_done", 32'(awg_done), 32'(abort_after == 0));
    m_phase = (abort_after > 0 && !cont) ? 32'h0 : exp_phase(p0, f0, c, down, emitted);
    awg_enable = 1'b0;
    if (abort_after == 0) begin
      @(negedge clk);
      check("done_pulse_end", 32'(awg_done), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(awg_ready), 32'd0);
    check("rst_active", 32'(awg_active), 32'd0);
    check("rst_done", 32'(awg_done), 32'd0);
    check("rst_valid", 32'(phase_valid), 32'd0);
    check("rst_phase", phase_out, 32'd0);
    reset_n = 1'b1;
    warmup();
    write_reg(SR_FREQ_OFFSET_DEF, 32'h100);
    write_reg(SR_TUNING_COEF_DEF, 32'h10);
    write_reg(SR_COUNTER_MAX_DEF, 32'd3);
    write_reg(SR_CTRL_WORD_DEF, 32'h0);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("held_phase_after_up", m_phase, 32'h460);
    write_reg(SR_CTRL_WORD_DEF, 32'h2);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    write_reg(SR_CTRL_WORD_DEF, 32'h1);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    write_reg(SR_CTRL_WORD_DEF, 32'h0);
    run_chirp(0, 1'b1, 32'd5, 1'b0, '0, 1'b0);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    write_reg(SR_COUNTER_MAX_DEF, 32'd7);
    run_chirp(2, 1'b0, '0, 1'b0, '0, 1'b0);
    run_chirp(0, 1'b0, '0, 1'b1, 32'h20, 1'b0);
    write_reg(SR_COUNTER_MAX_DEF, 32'd0);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    write_reg(8'd7, $urandom);
    write_reg(8'd0, $urandom);
    write_reg(SR_COUNTER_MAX_DEF, 32'd2);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    wait_ready();
    awg_init = 1'b1;
    @(negedge clk);
    awg_init = 1'b0;
    check("init_no_enable", 32'(phase_valid), 32'd0);
    dac_ready = 1'b0;
    @(negedge clk);
    check("dac_not_ready", 32'(awg_ready), 32'd0);
    awg_init = 1'b1; awg_enable = 1'b1;
    @(negedge clk);
    awg_init = 1'b0; awg_enable = 1'b0;
    check("start_blocked", 32'(phase_valid), 32'd0);
    dac_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      logic [31:0] cm;
      int ab;
      cm = $urandom_range(0, 12);
      write_reg(SR_FREQ_OFFSET_DEF, $urandom);
      write_reg(SR_TUNING_COEF_DEF, $urandom);
      write_reg(SR_COUNTER_MAX_DEF, cm);
      write_reg(SR_CTRL_WORD_DEF, $urandom);
      write_reg(8'($urandom_range(7, 255)), $urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(cm) + 1)) : 0;
      run_chirp(ab, 1'b0, '0, 1'b0, '0, 1'b0);
    end
    write_reg(SR_CTRL_WORD_DEF, 32'h0);
    write_reg(SR_COUNTER_MAX_DEF, 32'd10);
    wait_ready();
    awg_init = 1'b1; awg_enable = 1'b1;
    @(negedge clk);
    awg_init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_active", 32'(awg_active), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_active", 32'(awg_active), 32'd0);
    check("async_rst_valid", 32'(phase_valid), 32'd0);
    check("async_rst_phase", phase_out, 32'd0);
    check("async_rst_done", 32'(awg_done), 32'd0);
    awg_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    warmup();
    write_reg(SR_COUNTER_MAX_DEF, 32'd2);
    run_chirp(0, 1'b0, '0, 1'b0, '0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
